q65_bus_fabric: RTL

Two-segment internal data bus for the quasi6502 core, parametrised in width and driver count. It replaces the per-source tri-state drivers and the two-way bus bridge with an explicit mux-and-resolve fabric. Each segment is resolved with NMOS wired-AND semantics, where pull-down wins. Each segment also keeps a bus-hold latch that retains the last driven value for a bounded number of cycles before decaying to the precharge value. Per-segment contention is tracked in sticky flags. The fabric sits between the register file / ALU sources and the datapath consumers, and is synthesisable with no internal `z`.

---
 rtl/q65_bus_pkg.sv | 42 ++++
 rtl/q65_bus_fabric_if.sv | 40 ++++
 rtl/q65_bus_segment.sv | 95 +++++++++
 rtl/q65_bus_fabric.sv | 98 +++++++++
 4 files changed

// File: rtl/q65_bus_pkg.sv
// Shared constants and helpers for the quasi6502 two-segment bus fabric.
// Pure declarations: no state, no latency.
// No flow control; helpers are combinational reductions.
package q65_bus_pkg;

    localparam int                   Q65_WIDTH     = 8;
    localparam logic [Q65_WIDTH-1:0] Q65_PRECHARGE = '1;

    // Upper bound on drivers per segment that the helpers can reduce over.
    localparam int                   MAX_DRV       = 32;

    // Wired-AND of one bit column: lane i contributes only when enabled.
    // With no lane enabled the column floats high (pull-up), hence 1.
    function automatic logic and_reduce_en(input logic [MAX_DRV-1:0] data,
                                           input logic [MAX_DRV-1:0] en,
                                           input int                 n);
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < MAX_DRV; i++) begin
            if (i < n && en[i]) begin
                acc = acc & data[i];
            end
        end
        return acc;
    endfunction

    // True when at least two enable bits are set.
    function automatic logic popcount_ge2(input logic [MAX_DRV-1:0] en);
        logic seen;
        logic two;
        seen = 1'b0;
        two  = 1'b0;
        for (int i = 0; i < MAX_DRV; i++) begin
            if (en[i]) begin
                two  = two | seen;
                seen = 1'b1;
            end
        end
        return two;
    endfunction

endpackage

// File: rtl/q65_bus_fabric_if.sv
// Driver-side and consumer-side signal bundle of the bus fabric.
// Wiring only, zero latency.
// No backpressure: drivers are level enables, outputs are continuous.
interface q65_bus_fabric_if
    import q65_bus_pkg::*;
#(
    parameter int WIDTH  = Q65_WIDTH,
    parameter int NDRV_A = 4,
    parameter int NDRV_B = 4
) ();

    logic [NDRV_A*WIDTH-1:0] drv_a_data;
    logic [NDRV_A-1:0]       drv_a_en;
    logic [NDRV_B*WIDTH-1:0] drv_b_data;
    logic [NDRV_B-1:0]       drv_b_en;
    logic                    pass_ab;
    logic                    pass_ba;
    logic                    clear_contention;
    logic [WIDTH-1:0]        bus_a;
    logic [WIDTH-1:0]        bus_b;
    logic                    driven_a;
    logic                    driven_b;
    logic                    contention_a;
    logic                    contention_b;

    // Sources and control side
    modport master (
        output drv_a_data, drv_a_en, drv_b_data, drv_b_en,
        output pass_ab, pass_ba, clear_contention,
        input  bus_a, bus_b, driven_a, driven_b, contention_a, contention_b
    );

    // Fabric side
    modport slave (
        input  drv_a_data, drv_a_en, drv_b_data, drv_b_en,
        input  pass_ab, pass_ba, clear_contention,
        output bus_a, bus_b, driven_a, driven_b, contention_a, contention_b
    );

endinterface

// File: rtl/q65_bus_segment.sv
// One bus segment: local wired-AND resolution, bus-hold latch with decay, sticky contention flag.
// Resolution outputs are combinational; hold/flag state updates one edge later.
// No backpressure; final bus/driven/contention come back from the bridge logic.
module q65_bus_segment
    import q65_bus_pkg::*;
#(
    parameter int               WIDTH       = Q65_WIDTH,
    parameter int               NDRV        = 4,
    parameter int               HOLD_CYCLES = 4,
    parameter logic [WIDTH-1:0] PRECHARGE   = '1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NDRV*WIDTH-1:0]  drv_data_i,
    input  logic [NDRV-1:0]        drv_en_i,
    input  logic                   clear_contention_i,
    input  logic [WIDTH-1:0]       bus_i,
    input  logic                   driven_i,
    input  logic                   cont_cond_i,
    output logic [WIDTH-1:0]       loc_val_o,
    output logic                   loc_any_o,
    output logic                   loc_ge2_o,
    output logic [WIDTH-1:0]       idle_val_o,
    output logic [WIDTH-1:0]       own_val_o,
    output logic                   contention_o
);

    // A zero hold still needs a one-bit counter that simply stays at zero.
    localparam int               CNT_W    = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    logic [WIDTH-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_q, flag_d;
    logic [MAX_DRV-1:0] en_wide;

    // Local wired-AND, resolved one bit column at a time
    always_comb begin
        logic [MAX_DRV-1:0] col;
        en_wide               = '0;
        en_wide[NDRV-1:0]     = drv_en_i;
        loc_val_o             = '1;
        col                   = '0;
        for (int b = 0; b < WIDTH; b++) begin
            col = '0;
            for (int i = 0; i < NDRV; i++) begin
                col[i] = drv_data_i[i*WIDTH + b];
            end
            loc_val_o[b] = and_reduce_en(col, en_wide, NDRV);
        end
        loc_any_o = |drv_en_i;
        loc_ge2_o = popcount_ge2(en_wide);
    end

    // Idle value decays to precharge once the hold window has run out
    always_comb begin
        idle_val_o = (cnt_q < HOLD_MAX) ? hold_q : PRECHARGE;
        own_val_o  = loc_any_o ? loc_val_o : idle_val_o;
    end

    // Next state: recapture on a driven cycle, otherwise age with saturation
    always_comb begin
        hold_d = hold_q;
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (driven_i) begin
            hold_d = bus_i;
            cnt_d  = '0;
        end else if (cnt_q < HOLD_MAX) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
        // A new contention event wins over a simultaneous clear
        if (cont_cond_i) begin
            flag_d = 1'b1;
        end else if (clear_contention_i) begin
            flag_d = 1'b0;
        end
    end

    // Hold latch, age counter and sticky flag
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= PRECHARGE;
            cnt_q  <= HOLD_MAX;
            flag_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign contention_o = flag_q;

endmodule

// File: rtl/q65_bus_fabric.sv
// Two-segment wired-AND bus with A<->B bridge, merged mode, bus hold and contention tracking.
// Bus values and driven flags are combinational; hold and contention flags register on the edge.
// No backpressure: every enabled driver is resolved in the cycle it is enabled.
module q65_bus_fabric
    import q65_bus_pkg::*;
#(
    parameter int               WIDTH       = Q65_WIDTH,
    parameter int               NDRV_A      = 4,
    parameter int               NDRV_B      = 4,
    parameter int               HOLD_CYCLES = 4,
    parameter logic [WIDTH-1:0] PRECHARGE   = '1
) (
    input  logic           clk,
    input  logic           reset,
    q65_bus_fabric_if.slave bus_if
);

    logic [WIDTH-1:0] loc_a, loc_b, idle_a, idle_b, own_a, own_b;
    logic             any_a, any_b, ge2_a, ge2_b;
    logic [WIDTH-1:0] bus_a, bus_b;
    logic             driven_a, driven_b, cond_a, cond_b;
    logic             merged, total_ge2;

    q65_bus_segment #(
        .WIDTH(WIDTH), .NDRV(NDRV_A), .HOLD_CYCLES(HOLD_CYCLES), .PRECHARGE(PRECHARGE)
    ) u_seg_a (
        .clk                (clk),
        .reset              (reset),
        .drv_data_i         (bus_if.drv_a_data),
        .drv_en_i           (bus_if.drv_a_en),
        .clear_contention_i (bus_if.clear_contention),
        .bus_i              (bus_a),
        .driven_i           (driven_a),
        .cont_cond_i        (cond_a),
        .loc_val_o          (loc_a),
        .loc_any_o          (any_a),
        .loc_ge2_o          (ge2_a),
        .idle_val_o         (idle_a),
        .own_val_o          (own_a),
        .contention_o       (bus_if.contention_a)
    );

    q65_bus_segment #(
        .WIDTH(WIDTH), .NDRV(NDRV_B), .HOLD_CYCLES(HOLD_CYCLES), .PRECHARGE(PRECHARGE)
    ) u_seg_b (
        .clk                (clk),
        .reset              (reset),
        .drv_data_i         (bus_if.drv_b_data),
        .drv_en_i           (bus_if.drv_b_en),
        .clear_contention_i (bus_if.clear_contention),
        .bus_i              (bus_b),
        .driven_i           (driven_b),
        .cont_cond_i        (cond_b),
        .loc_val_o          (loc_b),
        .loc_any_o          (any_b),
        .loc_ge2_o          (ge2_b),
        .idle_val_o         (idle_b),
        .own_val_o          (own_b),
        .contention_o       (bus_if.contention_b)
    );

    // Bridge / merge mux and per-segment contention conditions
    always_comb begin
        merged    = bus_if.pass_ab & bus_if.pass_ba;
        total_ge2 = ge2_a | ge2_b | (any_a & any_b);
        bus_a     = own_a;
        bus_b     = own_b;
        driven_a  = any_a;
        driven_b  = any_b;
        if (merged) begin
            if (any_a | any_b) begin
                // Undriven side contributes all-ones, so this is the AND of all enabled lanes
                bus_a    = loc_a & loc_b;
                driven_a = 1'b1;
            end else begin
                bus_a    = idle_a & idle_b;
                driven_a = 1'b0;
            end
            bus_b    = bus_a;
            driven_b = driven_a;
        end else if (bus_if.pass_ab) begin
            bus_b    = any_b ? (own_a & loc_b) : own_a;
            driven_b = 1'b1;
        end else if (bus_if.pass_ba) begin
            bus_a    = any_a ? (own_b & loc_a) : own_b;
            driven_a = 1'b1;
        end
        // A segment receiving a pass counts its own single driver as a fight
        cond_a = ge2_a | (any_a & bus_if.pass_ba) | (merged & total_ge2);
        cond_b = ge2_b | (any_b & bus_if.pass_ab) | (merged & total_ge2);
    end

    assign bus_if.bus_a    = bus_a;
    assign bus_if.bus_b    = bus_b;
    assign bus_if.driven_a = driven_a;
    assign bus_if.driven_b = driven_b;

endmodule
